ntv_timer_responder: RTL and testbench

Machine-timer peripheral that sits on the core's data-side native memory interface as a responder, alongside the data memory. It decodes its own 32-byte window, services byte-enabled reads and writes to mtime, mtimecmp, control and status registers with a fixed one-cycle read latency, and drives the machine timer interrupt (mtip) into the core.

---
 rtl/risc_v_core_pkg.sv | 43 ++++
 rtl/ntv_timer_prescaler.sv | 44 ++++
 rtl/ntv_timer_responder.sv | 142 ++++++++++++++
 tb/tb_ntv_timer_responder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_v_core_pkg
// Description : Shared definitions for the native-interface machine timer:
//               register offsets (addr[4:2]), CTRL field layout, the mtimecmp
//               reset value and a byte-lane merge helper for partial writes.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_v_core_pkg;

   // Register offsets, decoded from addr[4:2]
   localparam logic [2:0] TIMER_MTIME_LO    = 3'd0;
   localparam logic [2:0] TIMER_MTIME_HI    = 3'd1;
   localparam logic [2:0] TIMER_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] TIMER_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] TIMER_CTRL        = 3'd4;
   localparam logic [2:0] TIMER_STATUS      = 3'd5;

   // CTRL occupies bit 0 (EN) and bits [31:8] at most (PRESCALE); the
   // responder masks PRESCALE down to its configured width.
   localparam int unsigned TIMER_PRESCALE_MAX_W = 24;

   typedef struct packed {
      logic [TIMER_PRESCALE_MAX_W-1:0] prescale;
      logic                            en;
   } timer_ctrl_t;

   localparam logic [63:0] TIMER_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   // Replace each byte of old_val whose lane enable is set.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ntv_timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : ntv_timer_prescaler
// Description : Prescale counter and tick generator. While en is high the
//               counter runs 0..prescale; tick is asserted in the cycle the
//               counter equals prescale, and the counter wraps to 0.
//               clr forces the counter to 0 on the next edge.
// Ports       : clk, rst_n (async, active-low), en, prescale[PRESCALE_W-1:0],
//               clr, tick (combinational, one cycle per period)
// Revision    : 1.0 - initial release
// ============================================================================
module ntv_timer_prescaler #(
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  clr,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] cnt_q;
   logic [PRESCALE_W-1:0] cnt_d;

   always_comb begin
      tick  = en && (cnt_q == prescale);
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule
`default_nettype wire

// File: rtl/ntv_timer_responder.sv
`default_nettype none
// ============================================================================
// Module      : ntv_timer_responder
// Description : Machine timer responder on the data-side native interface.
//               Decodes a 32-byte window at BASE_ADDR, serves byte-enabled
//               writes and one-cycle-latency reads of MTIME, MTIMECMP, CTRL
//               and STATUS, and drives the registered mtip interrupt.
// Ports       : clk, rst_n (async, active-low), r_en, w_en, addr[31:0],
//               wdata[31:0], byteenable[3:0] -> rdata[31:0], resp_hit, mtip
// Config      : NTV_TIMER_HI_SNAPSHOT_EN - a read of MTIME_LO latches
//               mtime[63:32] into a shadow that later MTIME_HI reads return.
// Revision    : 1.0 - initial release
// ============================================================================
module ntv_timer_responder
   import risc_v_core_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        r_en,
   input  logic        w_en,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byteenable,
   output logic [31:0] rdata,
   output logic        resp_hit,
   output logic        mtip
);

   localparam logic [31:0] PS_MASK = (32'd1 << PRESCALE_W) - 32'd1;

   logic [63:0] mtime_q, mtime_d, mtime_inc;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   timer_ctrl_t ctrl_q, ctrl_d;
   logic [31:0] ctrl_img, ctrl_wr;
   logic [31:0] rdata_q, rdata_d, rd_val;
   logic        resp_hit_q, resp_hit_d;
   logic        mtip_q, mtip_d;
   logic        hit, wr, rd, tick, ctrl_clr;
   logic [2:0]  reg_sel;
   logic        addr_lo_unused;

   assign hit      = (addr[31:5] == BASE_ADDR[31:5]);
   assign reg_sel  = addr[4:2];
   // A zero byteenable is treated as no write at all (not even a CTRL clear).
   assign wr       = w_en && hit && (|byteenable);
   assign rd       = r_en && hit;
   assign ctrl_clr = wr && (reg_sel == TIMER_CTRL);
   assign ctrl_img = {ctrl_q.prescale, 7'd0, ctrl_q.en};
   assign addr_lo_unused = ^addr[1:0];

   ntv_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (ctrl_q.en),
      .prescale (ctrl_q.prescale[PRESCALE_W-1:0]),
      .clr      (ctrl_clr),
      .tick     (tick)
   );

`ifdef NTV_TIMER_HI_SNAPSHOT_EN
   logic [31:0] shadow_q, shadow_d;

   assign shadow_d = (rd && reg_sel == TIMER_MTIME_LO) ? mtime_q[63:32] : shadow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) shadow_q <= '0;
      else        shadow_q <= shadow_d;
   end
`endif

   // Register state update: increment first, then let a CPU write override
   // the addressed half. The untouched half keeps the incremented value.
   always_comb begin
      mtime_inc  = mtime_q + {63'd0, tick};
      mtime_d    = mtime_inc;
      mtimecmp_d = mtimecmp_q;
      ctrl_d     = ctrl_q;
      ctrl_wr    = byte_merge(ctrl_img, wdata, byteenable);
      if (wr) begin
         case (reg_sel)
            TIMER_MTIME_LO:    mtime_d[31:0]     = byte_merge(mtime_q[31:0], wdata, byteenable);
            TIMER_MTIME_HI:    mtime_d[63:32]    = byte_merge(mtime_q[63:32], wdata, byteenable);
            TIMER_MTIMECMP_LO: mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0], wdata, byteenable);
            TIMER_MTIMECMP_HI: mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], wdata, byteenable);
            TIMER_CTRL: begin
               ctrl_d.en       = ctrl_wr[0];
               ctrl_d.prescale = ctrl_wr[31:8] & PS_MASK[23:0];
            end
            default: ;
         endcase
      end
      mtip_d = (mtime_d >= mtimecmp_d);
   end

   // Read path samples pre-write values so a combined read+write returns the
   // old contents.
   always_comb begin
      case (reg_sel)
         TIMER_MTIME_LO:    rd_val = mtime_q[31:0];
`ifdef NTV_TIMER_HI_SNAPSHOT_EN
         TIMER_MTIME_HI:    rd_val = shadow_q;
`else
         TIMER_MTIME_HI:    rd_val = mtime_q[63:32];
`endif
         TIMER_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
         TIMER_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
         TIMER_CTRL:        rd_val = ctrl_img;
         TIMER_STATUS:      rd_val = {31'd0, mtip_q};
         default:           rd_val = 32'd0;
      endcase
      rdata_d = rdata_q;
      if (r_en) rdata_d = hit ? rd_val : 32'd0;
      resp_hit_d = rd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime_q    <= '0;
         mtimecmp_q <= TIMER_MTIMECMP_RST;
         ctrl_q     <= '0;
         rdata_q    <= '0;
         resp_hit_q <= 1'b0;
         mtip_q     <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         ctrl_q     <= ctrl_d;
         rdata_q    <= rdata_d;
         resp_hit_q <= resp_hit_d;
         mtip_q     <= mtip_d;
      end
   end

   assign rdata    = rdata_q;
   assign resp_hit = resp_hit_q;
   assign mtip     = mtip_q;

endmodule
`default_nettype wire

// File: tb/tb_ntv_timer_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntv_timer_responder
// Description : Self-checking bench for ntv_timer_responder: a vector table
//               for register access, hand-written timing sequences, and a
//               randomized phase checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntv_timer_responder;

   localparam logic [31:0] BASE = 32'h0200_0000;
   localparam int          PW   = 8;
   localparam logic [31:0] CTRL_MASK = 32'h0000_0001 | (((32'd1 << PW) - 32'd1) << 8);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        r_en = 1'b0;
   logic        w_en = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  byteenable = '0;
   logic [31:0] rdata;
   logic        resp_hit;
   logic        mtip;

   int n_checks = 0;
   int n_pass   = 0;

   ntv_timer_responder #(.BASE_ADDR(BASE), .PRESCALE_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .r_en(r_en), .w_en(w_en), .addr(addr),
      .wdata(wdata), .byteenable(byteenable), .rdata(rdata),
      .resp_hit(resp_hit), .mtip(mtip)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   bit          model_on = 1'b0;
   logic [63:0] m_mtime, m_cmp;
   logic [31:0] m_ctrl, m_rdata, m_shadow;
   int unsigned m_pcnt;
   logic        m_mtip, m_hit;

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] b);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_ctrl = 32'd0;
      m_rdata = 32'd0; m_shadow = 32'd0; m_pcnt = 0; m_mtip = 1'b0; m_hit = 1'b0;
   endtask

   // One clock of the timer, from the register-level rules.
   task automatic model_step();
      bit          hit, wr, en, tick;
      int          off;
      int unsigned ps;
      logic [31:0] rv;
      logic [63:0] nt;
      hit  = (addr[31:5] == BASE[31:5]);
      off  = int'(addr[4:2]);
      wr   = w_en && hit && (byteenable != 4'd0);
      en   = m_ctrl[0];
      ps   = int'(m_ctrl[8 +: PW]);
      tick = en && (m_pcnt == ps);
      nt   = m_mtime + (tick ? 64'd1 : 64'd0);
      case (off)
         0: rv = m_mtime[31:0];
`ifdef NTV_TIMER_HI_SNAPSHOT_EN
         1: rv = m_shadow;
`else
         1: rv = m_mtime[63:32];
`endif
         2: rv = m_cmp[31:0];
         3: rv = m_cmp[63:32];
         4: rv = m_ctrl;
         5: rv = {31'd0, m_mtip};
         default: rv = 32'd0;
      endcase
      if (r_en) m_rdata = hit ? rv : 32'd0;
      m_hit = r_en && hit;
      if (r_en && hit && off == 0) m_shadow = m_mtime[63:32];
      if (wr && off == 4)  m_pcnt = 0;
      else if (tick)       m_pcnt = 0;
      else if (en)         m_pcnt = m_pcnt + 1;
      if (wr) begin
         case (off)
            0: nt[31:0]    = merge(m_mtime[31:0], wdata, byteenable);
            1: nt[63:32]   = merge(m_mtime[63:32], wdata, byteenable);
            2: m_cmp[31:0] = merge(m_cmp[31:0], wdata, byteenable);
            3: m_cmp[63:32]= merge(m_cmp[63:32], wdata, byteenable);
            4: m_ctrl      = merge(m_ctrl, wdata, byteenable) & CTRL_MASK;
            default: ;
         endcase
      end
      m_mtime = nt;
      m_mtip  = (m_mtime >= m_cmp);
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      if (model_on) model_step();
      #1;
   endtask

   task automatic acc(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b);
      r_en = r; w_en = w; addr = a; wdata = d; byteenable = b;
      step();
      r_en = 1'b0; w_en = 1'b0;
   endtask

   task automatic rd(input logic [2:0] off);
      acc(1'b1, 1'b0, BASE + {27'd0, off, 2'b00}, 32'd0, 4'h0);
   endtask

   task automatic wr(input logic [2:0] off, input logic [31:0] d);
      acc(1'b0, 1'b1, BASE + {27'd0, off, 2'b00}, d, 4'hF);
   endtask

   typedef struct {
      logic        r, w;
      logic [31:0] a, d;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      logic        exp_hit;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] be,
                               input logic [31:0] er, input logic eh);
      vec_t v;
      v.r = r; v.w = w; v.a = a; v.d = d; v.be = be; v.exp_rd = er; v.exp_hit = eh;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      logic [31:0] v0, v1;
      int          k;
      bit          seen;
      int          off;

      // ---- reset state ----
      #12;
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_resp_hit", resp_hit, 1'b0);
      chk("rst_mtip", mtip, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- table-driven register access ----
      tbl.push_back(mk(1,0, BASE+32'h00, 0, 4'h0, 32'h0, 1));
      tbl.push_back(mk(1,0, BASE+32'h04, 0, 4'h0, 32'h0, 1));
      tbl.push_back(mk(1,0, BASE+32'h08, 0, 4'h0, 32'hFFFF_FFFF, 1));
      tbl.push_back(mk(1,0, BASE+32'h0C, 0, 4'h0, 32'hFFFF_FFFF, 1));
      tbl.push_back(mk(1,0, BASE+32'h20, 0, 4'h0, 32'h0, 0));          // miss
      tbl.push_back(mk(1,0, BASE+32'h10, 0, 4'h0, 32'h0, 1));
      tbl.push_back(mk(1,0, BASE+32'h14, 0, 4'h0, 32'h0, 1));
      tbl.push_back(mk(0,1, BASE+32'h18, 32'hFFFF_FFFF, 4'hF, 32'h0, 0));
      tbl.push_back(mk(1,0, BASE+32'h18, 0, 4'h0, 32'h0, 1));          // reserved
      tbl.push_back(mk(1,0, BASE+32'h1C, 0, 4'h0, 32'h0, 1));
      tbl.push_back(mk(1,0, BASE+32'h08, 0, 4'h0, 32'hFFFF_FFFF, 1));
      tbl.push_back(mk(0,1, BASE+32'h10, 32'h0000_0300, 4'hF, 32'hFFFF_FFFF, 0)); // rdata holds
      tbl.push_back(mk(1,1, BASE+32'h10, 32'h0000_0301, 4'hF, 32'h0000_0300, 1)); // old CTRL
      tbl.push_back(mk(0,1, BASE+32'h10, 32'h0000_0000, 4'hF, 32'h0000_0300, 0));
      tbl.push_back(mk(1,0, BASE+32'h10, 0, 4'h0, 32'h0, 1));
      tbl.push_back(mk(0,1, BASE+32'h10, 32'hFFFF_FF00, 4'hE, 32'h0, 0));
      tbl.push_back(mk(1,0, BASE+32'h10, 0, 4'h0, 32'h0000_FF00, 1));  // prescale masked
      tbl.push_back(mk(0,1, BASE+32'h10, 32'h0, 4'hF, 32'h0000_FF00, 0));
      tbl.push_back(mk(0,1, BASE+32'h00, 32'h1234_5678, 4'hF, 32'h0000_FF00, 0));
      tbl.push_back(mk(0,1, BASE+32'h00, 32'h0000_AB00, 4'h2, 32'h0000_FF00, 0));
      tbl.push_back(mk(1,0, BASE+32'h00, 0, 4'h0, 32'h1234_AB78, 1));
      tbl.push_back(mk(0,1, BASE+32'h00, 32'hFFFF_FFFF, 4'h0, 32'h1234_AB78, 0));
      tbl.push_back(mk(0,1, BASE+32'h20, 32'h0, 4'hF, 32'h1234_AB78, 0)); // miss write
      tbl.push_back(mk(1,0, BASE+32'h00, 0, 4'h0, 32'h1234_AB78, 1));
      tbl.push_back(mk(0,1, BASE+32'h0C, 32'hA5A5_A5A5, 4'h8, 32'h1234_AB78, 0));
      tbl.push_back(mk(1,0, BASE+32'h0C, 0, 4'h0, 32'hA5FF_FFFF, 1));
      tbl.push_back(mk(1,0, BASE+32'h14, 0, 4'h0, 32'h0, 1));
      for (int i = 0; i < tbl.size(); i++) begin
         acc(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be);
         chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_resp_hit", i), resp_hit, tbl[i].exp_hit);
         chk($sformatf("tbl%0d_mtip", i), mtip, 1'b0);
      end

      // ---- prescaler: PRESCALE=3 -> one increment per 4 cycles ----
      wr(3'd0, 32'd0); wr(3'd1, 32'd0);
      wr(3'd4, 32'h0000_0301);
      repeat (40) step();
      rd(3'd0);
      n_checks++;
      if (rdata >= 32'd9 && rdata <= 32'd11) n_pass++;
      else $display("FAIL prescale_count: got %0d, expected 10 +/- 1", rdata);
      wr(3'd4, 32'd0);
      rd(3'd0); v0 = rdata;
      repeat (20) step();
      rd(3'd0); v1 = rdata;
      chk("disabled_holds", v1, v0);

      // ---- mtip rise and fall ----
      wr(3'd0, 32'd0); wr(3'd1, 32'd0);
      wr(3'd3, 32'd0); wr(3'd2, 32'd5);
      chk("mtip_before", mtip, 1'b0);
      wr(3'd4, 32'h0000_0001);
      seen = 1'b0; k = 0;
      while (!seen && k < 30) begin
         step(); k++;
         if (mtip) seen = 1'b1;
      end
      if (!seen) begin
         n_checks++;
         $display("FAIL mtip_rise: got no rise within %0d cycles, expected rise after 5", k);
      end else chk("mtip_rise_cycle", k, 5);
      wr(3'd2, 32'hFFFF_FFFF);
      chk("mtip_fall", mtip, 1'b0);
      wr(3'd4, 32'd0);

      // ---- carry from LO into HI, and full 64-bit wrap ----
      wr(3'd1, 32'd0); wr(3'd0, 32'hFFFF_FFFF);
      wr(3'd4, 32'h1); wr(3'd4, 32'h0);
      rd(3'd0); chk("carry_lo", rdata, 32'd0);
      rd(3'd1); chk("carry_hi", rdata, 32'd1);
      wr(3'd1, 32'hFFFF_FFFF); wr(3'd0, 32'hFFFF_FFFF);
      wr(3'd4, 32'h1); wr(3'd4, 32'h0);
      rd(3'd0); chk("wrap_lo", rdata, 32'd0);
      rd(3'd1); chk("wrap_hi", rdata, 32'd0);
      chk("wrap_mtip", mtip, 1'b0);

      // ---- HI snapshot across a carry ----
      wr(3'd1, 32'd0); wr(3'd0, 32'hFFFF_FFFE);
      wr(3'd4, 32'h1);
      rd(3'd0); chk("snap_lo", rdata, 32'hFFFF_FFFE);
      step();
      wr(3'd4, 32'h0);
      rd(3'd1);
`ifdef NTV_TIMER_HI_SNAPSHOT_EN
      chk("snap_hi", rdata, 32'd0);
`else
      chk("snap_hi", rdata, 32'd1);
`endif
      rd(3'd0); chk("snap_lo_after", rdata, 32'd1);

      // ---- randomized phase against the model ----
      rst_n = 1'b0;
      #2;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      model_on = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         off = $urandom_range(0, 7);
         r_en = 1'($urandom_range(0, 1));
         w_en = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 15) == 0) addr = BASE ^ (32'd1 << $urandom_range(5, 31));
         else addr = BASE | {27'd0, 3'(off), 2'($urandom_range(0, 3))};
         case (off)
            4:    wdata = {16'd0, 8'($urandom_range(0, 3)), 7'($urandom), 1'($urandom)};
            1, 3: wdata = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
            default: wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 80));
         endcase
         byteenable = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         step();
         chk($sformatf("rnd%0d_rdata", c), rdata, m_rdata);
         chk($sformatf("rnd%0d_resp_hit", c), resp_hit, m_hit);
         chk($sformatf("rnd%0d_mtip", c), mtip, m_mtip);
         if (c == 1500) begin
            // asynchronous reset in the middle of traffic
            rst_n = 1'b0;
            #1;
            chk("midrst_rdata", rdata, 32'd0);
            chk("midrst_resp_hit", resp_hit, 1'b0);
            chk("midrst_mtip", mtip, 1'b0);
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      r_en = 1'b0; w_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
